gcd_datapath: RTL and testbench

- Datapath half of the subtractive GCD engine.
- Responds to the GCD controller's ld/sel strobes and holds the X, Y and result registers.
- Generates the x_neq_y / x_lt_y status flags the controller branches on.
- Adds a result-valid strobe, an iteration counter with timeout, and error flags, so the pair is observable and cannot hang silently.

---
 rtl/gcd_pkg.sv | 21 ++
 rtl/gcd_sub_reg.sv | 47 ++++
 rtl/gcd_datapath.sv | 128 ++++++++++++
 tb/tb_gcd_datapath.sv | 137 +++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared widths, select encodings and controller states for the GCD pair
package gcd_pkg;

  localparam int WIDTH_DEF    = 4;
  localparam int CNT_W_DEF    = 4;
  localparam int MAX_ITER_DEF = 15;

  localparam logic SEL_INPUT = 1'b0;
  localparam logic SEL_SUB   = 1'b1;

  // Controller encodings live here so controller and datapath benches agree
  typedef enum logic [2:0] {
    CTRL_IDLE  = 3'd0,
    CTRL_LOAD  = 3'd1,
    CTRL_CMP   = 3'd2,
    CTRL_SUB_X = 3'd3,
    CTRL_SUB_Y = 3'd4,
    CTRL_DONE  = 3'd5
  } gcd_ctrl_state_e;

endpackage

// File: rtl/gcd_sub_reg.sv
// rtl/gcd_sub_reg.sv - one operand register with input/subtract mux and underflow guard
module gcd_sub_reg
  import gcd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_i,
  input  logic             sel_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [WIDTH-1:0] other_i,
  output logic [WIDTH-1:0] q_o,
  output logic             guard_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             guard;

  always_comb begin
    q_d   = q_q;
    guard = 1'b0;
    if (ld_i) begin
      if (sel_i == SEL_INPUT) begin
        q_d = din_i;
      end else if (q_q < other_i) begin
        // Underflowing subtract is refused; the register holds its value
        guard = 1'b1;
      end else begin
        q_d = q_q - other_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o     = q_q;
  assign guard_o = guard;

endmodule

// File: rtl/gcd_datapath.sv
// rtl/gcd_datapath.sv - subtractive GCD datapath with result capture, iteration timeout and error flags
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             x_ld,
  input  logic             x_sel,
  input  logic             y_ld,
  input  logic             y_sel,
  input  logic             d_ld,
  output logic             x_neq_y,
  output logic             x_lt_y,
  output logic [WIDTH-1:0] d_o,
  output logic             d_valid,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             timeout,
  output logic             zero_err,
  output logic             proto_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             x_guard;
  logic             y_guard;

  logic [WIDTH-1:0] d_q, d_d;
  logic             d_valid_q, d_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             zero_err_q, zero_err_d;
  logic             proto_err_q, proto_err_d;

  logic load_x, load_y, any_load, any_sub;

  gcd_sub_reg #(.WIDTH(WIDTH)) u_x_reg (
    .clk     (CLK),
    .rst_n   (RST_N),
    .ld_i    (x_ld),
    .sel_i   (x_sel),
    .din_i   (x_i),
    .other_i (y_q),
    .q_o     (x_q),
    .guard_o (x_guard)
  );

  gcd_sub_reg #(.WIDTH(WIDTH)) u_y_reg (
    .clk     (CLK),
    .rst_n   (RST_N),
    .ld_i    (y_ld),
    .sel_i   (y_sel),
    .din_i   (y_i),
    .other_i (x_q),
    .q_o     (y_q),
    .guard_o (y_guard)
  );

  assign load_x   = x_ld && (x_sel == SEL_INPUT);
  assign load_y   = y_ld && (y_sel == SEL_INPUT);
  assign any_load = load_x || load_y;
  assign any_sub  = (x_ld && (x_sel == SEL_SUB)) || (y_ld && (y_sel == SEL_SUB));

  always_comb begin
    cnt_d       = cnt_q;
    proto_err_d = proto_err_q;
    zero_err_d  = zero_err_q;
    d_d         = d_q;
    d_valid_d   = d_valid_q;

    // An operand load starts a new problem, so it overrides subtract bookkeeping
    if (any_load) begin
      cnt_d       = '0;
      proto_err_d = 1'b0;
      zero_err_d  = (load_x && (x_i == '0)) || (load_y && (y_i == '0));
      d_valid_d   = 1'b0;
    end else begin
      if (any_sub && (cnt_q != MAX_CNT)) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (x_guard || y_guard) begin
        proto_err_d = 1'b1;
      end
    end

    if (d_ld) begin
      d_d       = x_q;
      d_valid_d = 1'b1;
    end

    timeout_d = (cnt_d == MAX_CNT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
      zero_err_q  <= 1'b0;
      d_q         <= '0;
      d_valid_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
      zero_err_q  <= zero_err_d;
      d_q         <= d_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign x_neq_y   = (x_q != y_q);
  assign x_lt_y    = (x_q < y_q);
  assign d_o       = d_q;
  assign d_valid   = d_valid_q;
  assign iter_cnt  = cnt_q;
  assign timeout   = timeout_q;
  assign zero_err  = zero_err_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_gcd_datapath.sv
// tb/tb_gcd_datapath.sv - directed table-driven bench for gcd_datapath
module tb_gcd_datapath;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] x_i = '0, y_i = '0;
  logic       x_ld = 0, x_sel = 0, y_ld = 0, y_sel = 0, d_ld = 0;
  logic       x_neq_y, x_lt_y, d_valid, timeout, zero_err, proto_err;
  logic [3:0] d_o, iter_cnt;

  int checks = 0;
  int failures = 0;

  gcd_datapath #(.WIDTH(4), .MAX_ITER(4), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .x_i(x_i), .y_i(y_i),
    .x_ld(x_ld), .x_sel(x_sel), .y_ld(y_ld), .y_sel(y_sel), .d_ld(d_ld),
    .x_neq_y(x_neq_y), .x_lt_y(x_lt_y), .d_o(d_o), .d_valid(d_valid),
    .iter_cnt(iter_cnt), .timeout(timeout), .zero_err(zero_err), .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] op;   // {x_ld, x_sel, y_ld, y_sel, d_ld}
    int xi, yi;
    int d, dv, cnt, to, ze, pe, neq, lt;
  } vec_t;

  localparam logic [4:0] LD_XY = 5'b10100, LD_X = 5'b10000, SUB_X = 5'b11000,
                         SUB_Y = 5'b00110, SUB_XY = 5'b11110, CAP = 5'b00001,
                         LD_XY_CAP = 5'b10101, LD_Y_SUB_X = 5'b11100;

  vec_t tbl[28];

  function automatic vec_t mk(logic [4:0] op, int xi, int yi, int d, int dv, int cnt,
                              int to, int ze, int pe, int neq, int lt);
    vec_t v;
    v.op = op; v.xi = xi; v.yi = yi; v.d = d; v.dv = dv; v.cnt = cnt;
    v.to = to; v.ze = ze; v.pe = pe; v.neq = neq; v.lt = lt;
    return v;
  endfunction

  task automatic chk(string name, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0d required=%0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(int idx, int d, int dv, int cnt, int to, int ze, int pe, int neq, int lt);
    chk("d_o", idx, int'(d_o), d);
    chk("d_valid", idx, int'(d_valid), dv);
    chk("iter_cnt", idx, int'(iter_cnt), cnt);
    chk("timeout", idx, int'(timeout), to);
    chk("zero_err", idx, int'(zero_err), ze);
    chk("proto_err", idx, int'(proto_err), pe);
    chk("x_neq_y", idx, int'(x_neq_y), neq);
    chk("x_lt_y", idx, int'(x_lt_y), lt);
  endtask

  task automatic apply(logic [4:0] op, int xi, int yi);
    {x_ld, x_sel, y_ld, y_sel, d_ld} = op;
    x_i = 4'(xi);
    y_i = 4'(yi);
    @(posedge CLK);
    #1;
    {x_ld, x_sel, y_ld, y_sel, d_ld} = '0;
  endtask

  initial begin
    //               op         xi  yi   d dv cnt to ze pe neq lt
    tbl[0]  = mk(LD_XY,      12,  8,  0, 0, 0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(SUB_X,       0,  0,  0, 0, 1, 0, 0, 0, 1, 1);
    tbl[2]  = mk(SUB_Y,       0,  0,  0, 0, 2, 0, 0, 0, 0, 0);
    tbl[3]  = mk(CAP,         0,  0,  4, 1, 2, 0, 0, 0, 0, 0);
    tbl[4]  = mk(LD_XY,      15, 10,  4, 0, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mk(SUB_X,       0,  0,  4, 0, 1, 0, 0, 0, 1, 1);
    tbl[6]  = mk(SUB_Y,       0,  0,  4, 0, 2, 0, 0, 0, 0, 0);
    tbl[7]  = mk(CAP,         0,  0,  5, 1, 2, 0, 0, 0, 0, 0);
    tbl[8]  = mk(LD_XY,       0,  5,  5, 0, 0, 0, 1, 0, 1, 1);
    tbl[9]  = mk(LD_XY,       3,  3,  5, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(LD_XY,      15,  1,  5, 0, 0, 0, 0, 0, 1, 0);
    tbl[11] = mk(SUB_X,       0,  0,  5, 0, 1, 0, 0, 0, 1, 0);
    tbl[12] = mk(SUB_X,       0,  0,  5, 0, 2, 0, 0, 0, 1, 0);
    tbl[13] = mk(SUB_X,       0,  0,  5, 0, 3, 0, 0, 0, 1, 0);
    tbl[14] = mk(SUB_X,       0,  0,  5, 0, 4, 1, 0, 0, 1, 0);
    tbl[15] = mk(CAP,         0,  0, 11, 1, 4, 1, 0, 0, 1, 0);
    tbl[16] = mk(SUB_X,       0,  0, 11, 1, 4, 1, 0, 0, 1, 0);
    tbl[17] = mk(SUB_X,       0,  0, 11, 1, 4, 1, 0, 0, 1, 0);
    tbl[18] = mk(CAP,         0,  0,  9, 1, 4, 1, 0, 0, 1, 0);
    tbl[19] = mk(LD_XY,       3,  7,  9, 0, 0, 0, 0, 0, 1, 1);
    tbl[20] = mk(SUB_X,       0,  0,  9, 0, 1, 0, 0, 1, 1, 1);
    tbl[21] = mk(CAP,         0,  0,  3, 1, 1, 0, 0, 1, 1, 1);
    tbl[22] = mk(LD_X,        4,  0,  3, 0, 0, 0, 0, 0, 1, 1);
    tbl[23] = mk(LD_XY,       6,  6,  3, 0, 0, 0, 0, 0, 0, 0);
    tbl[24] = mk(SUB_XY,      0,  0,  3, 0, 1, 0, 0, 0, 0, 0);
    tbl[25] = mk(LD_XY_CAP,   9,  3,  0, 1, 0, 0, 0, 0, 1, 0);
    tbl[26] = mk(SUB_XY,      0,  0,  0, 1, 1, 0, 0, 1, 1, 0);
    tbl[27] = mk(LD_Y_SUB_X,  0, 10,  0, 0, 0, 0, 0, 0, 1, 1);

    #12;
    chk_all(-1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 28; i++) begin
      apply(tbl[i].op, tbl[i].xi, tbl[i].yi);
      chk_all(i, tbl[i].d, tbl[i].dv, tbl[i].cnt, tbl[i].to,
              tbl[i].ze, tbl[i].pe, tbl[i].neq, tbl[i].lt);
    end

    // Reach x=4, y=8, iter_cnt=1, d_valid=1, then reset asynchronously between edges
    apply(LD_XY, 12, 8);
    apply(SUB_X, 0, 0);
    apply(CAP, 0, 0);
    chk_all(100, 4, 1, 1, 0, 0, 0, 1, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk_all(101, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    RST_N = 1'b1;
    apply(LD_XY, 9, 6);
    chk_all(102, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(SUB_X, 0, 0);
    chk_all(103, 0, 0, 1, 0, 0, 0, 1, 1);
    apply(CAP, 0, 0);
    chk_all(104, 3, 1, 1, 0, 0, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
